// File: rtl/divider_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_checker_pkg
// Brief    : Shared types for the divider output checker.
// Revision : 1.0  initial release
// ============================================================================
package divider_checker_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with synchronous clear (clear beats inc).
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/divider_output_checker.sv
`default_nettype none
// ============================================================================
// Module   : divider_output_checker
// Brief    : Phase-locks to a one-hot-per-PERIOD pulse stream and flags errors.
// Revision : 1.0  initial release
// ============================================================================
module divider_output_checker
  import divider_checker_pkg::*;
#(
  parameter int PERIOD     = 4,
  parameter int LOCK_COUNT = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             y_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] pulse_count
);

  localparam int K_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int G_W = $clog2(LOCK_COUNT + 1);
  localparam logic [K_W-1:0] c_K_LAST    = K_W'(PERIOD - 1);
  localparam logic [G_W-1:0] c_GOOD_LOCK = G_W'(LOCK_COUNT);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [K_W-1:0] r_k;
  logic [K_W-1:0] w_k_nxt;
  logic [G_W-1:0] r_good;
  logic [G_W-1:0] w_good_nxt;
  logic [G_W-1:0] w_good_inc;
  logic           r_err_pulse;
  logic           w_err_nxt;
  logic           w_err_inc;
  logic           w_pulse_inc;

  logic w_at_last;
  logic w_hit_ok;
  logic w_low_ok;
  logic w_early;
  logic w_missed;

  // k counts lows since the last high; the high is due exactly at k == PERIOD-1
  assign w_at_last  = (r_k == c_K_LAST);
  assign w_hit_ok   =  y_in &  w_at_last;
  assign w_low_ok   = ~y_in & ~w_at_last;
  assign w_early    =  y_in & ~w_at_last;
  assign w_missed   = ~y_in &  w_at_last;
  assign w_good_inc = r_good + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_good_nxt  = r_good;
    w_err_nxt   = 1'b0;
    w_err_inc   = 1'b0;
    w_pulse_inc = 1'b0;

    if (!en) begin
      w_state_nxt = SEARCH;
      w_k_nxt     = '0;
      w_good_nxt  = '0;
    end else begin
      case (r_state)
        SEARCH: begin
          w_k_nxt    = '0;
          w_good_nxt = '0;
          if (y_in) begin
            w_state_nxt = TRACK;
          end
        end

        TRACK: begin
          if (w_low_ok) begin
            w_k_nxt = r_k + 1'b1;
          end else if (w_hit_ok) begin
            w_k_nxt    = '0;
            w_good_nxt = w_good_inc;
            if (w_good_inc == c_GOOD_LOCK) begin
              w_state_nxt = LOCKED;
            end
          end else if (w_early) begin
            w_k_nxt    = '0;
            w_good_nxt = '0;
          end else begin
            w_state_nxt = SEARCH;
            w_k_nxt     = '0;
            w_good_nxt  = '0;
          end
        end

        LOCKED: begin
          if (w_low_ok) begin
            w_k_nxt = r_k + 1'b1;
          end else if (w_hit_ok) begin
            w_k_nxt     = '0;
            w_pulse_inc = 1'b1;
          end else if (w_early) begin
            w_err_nxt   = 1'b1;
            w_err_inc   = 1'b1;
            w_state_nxt = TRACK;
            w_k_nxt     = '0;
            w_good_nxt  = '0;
          end else begin
            w_err_nxt   = 1'b1;
            w_err_inc   = 1'b1;
            w_state_nxt = SEARCH;
            w_k_nxt     = '0;
            w_good_nxt  = '0;
          end
        end

        default: begin
          w_state_nxt = SEARCH;
          w_k_nxt     = '0;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= SEARCH;
      r_k         <= '0;
      r_good      <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_good      <= w_good_nxt;
      r_err_pulse <= w_err_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (w_err_inc),
    .q     (err_count)
  );

  sat_counter #(.W(CNT_W)) u_pulse_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (w_pulse_inc),
    .q     (pulse_count)
  );

  assign locked    = (r_state == LOCKED);
  assign err_pulse = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_divider_output_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_output_checker
// Brief    : Directed self-checking bench (PERIOD=4, LOCK_COUNT=2; CNT_W 16 and 3).
// Revision : 1.0  initial release
// ============================================================================
module tb_divider_output_checker;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b0;
  logic        clear = 1'b0;
  logic        y_in  = 1'b0;

  logic        locked, err_pulse;
  logic [15:0] err_count, pulse_count;
  logic        locked_s, err_pulse_s;
  logic [2:0]  err_count_s, pulse_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_output_checker #(.PERIOD(4), .LOCK_COUNT(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .y_in(y_in),
    .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .pulse_count(pulse_count)
  );

  divider_output_checker #(.PERIOD(4), .LOCK_COUNT(2), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .y_in(y_in),
    .locked(locked_s), .err_pulse(err_pulse_s),
    .err_count(err_count_s), .pulse_count(pulse_count_s)
  );

  typedef struct {
    logic rst;
    logic ena;
    logic clr;
    logic y;
    logic e_locked;
    logic e_ep;
    int   e_ec;
    int   e_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic l, input logic ep, input int ec, input int pc);
    chk({name, ".locked"}, {31'd0, locked}, {31'd0, l});
    chk({name, ".err_pulse"}, {31'd0, err_pulse}, {31'd0, ep});
    chk({name, ".err_count"}, {16'd0, err_count}, ec);
    chk({name, ".pulse_count"}, {16'd0, pulse_count}, pc);
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic y);
    reset = r; en = e; clear = c; y_in = y;
    @(posedge clk);
    #1;
  endtask

  task automatic s(input logic y);
    step(1'b1, 1'b1, 1'b0, y);
  endtask

  task automatic interval();
    s(1'b0); s(1'b0); s(1'b0); s(1'b1);
  endtask

  task automatic relock();
    interval();
    interval();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //             rst   en    clr   y     lock  ep    ec pc
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].ena, vecs[i].clr, vecs[i].y);
      chk_all($sformatf("vec%0d", i), vecs[i].e_locked, vecs[i].e_ep, vecs[i].e_ec, vecs[i].e_pc);
    end

    // Ideal stream through sample 20 (k=1 now)
    s(1'b0); s(1'b0); s(1'b1);
    relock();
    chk_all("ideal_s20", 1'b1, 1'b0, 0, 3);

    // Early pulse at k=2 from LOCKED
    s(1'b0); s(1'b0); s(1'b1);
    chk_all("early_hit", 1'b0, 1'b1, 1, 3);
    s(1'b0);
    chk_all("early_after", 1'b0, 1'b0, 1, 3);
    s(1'b0); s(1'b0); s(1'b1);
    chk_all("early_int1", 1'b0, 1'b0, 1, 3);
    interval();
    chk_all("early_relock", 1'b1, 1'b0, 1, 3);
    interval();
    chk_all("early_resume", 1'b1, 1'b0, 1, 4);

    // Dropped pulse from LOCKED, then silent mismatches while reacquiring
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("clear_idle", 1'b1, 1'b0, 0, 0);
    s(1'b0); s(1'b0); s(1'b0);
    chk_all("missed_hit", 1'b0, 1'b1, 1, 0);
    s(1'b0); s(1'b0); s(1'b0);
    chk_all("missed_search", 1'b0, 1'b0, 1, 0);
    s(1'b1);
    s(1'b0); s(1'b1);
    chk_all("track_early_silent", 1'b0, 1'b0, 1, 0);
    interval();
    chk_all("missed_int1", 1'b0, 1'b0, 1, 0);
    interval();
    chk_all("missed_relock", 1'b1, 1'b0, 1, 0);

    // Saturation of the 3-bit instance
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat_clear_s", {29'd0, err_count_s}, 0);
    for (int i = 0; i < 10; i++) begin
      s(1'b1);
      relock();
    end
    chk("sat_ec_s", {29'd0, err_count_s}, 7);
    chk("sat_ec_wide", {16'd0, err_count}, 10);
    chk("sat_locked_s", {31'd0, locked_s}, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat_cleared_s", {29'd0, err_count_s}, 0);
    chk("sat_cleared_pc_s", {29'd0, pulse_count_s}, 0);

    // Clear on the same edge as a LOCKED early error
    s(1'b1);
    relock();
    chk_all("pre_clrerr", 1'b1, 1'b0, 1, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_all("clr_with_err", 1'b0, 1'b1, 0, 0);
    relock();

    // Reset mid-LOCKED with err_count=5
    for (int i = 0; i < 5; i++) begin
      s(1'b1);
      relock();
    end
    interval();
    chk_all("pre_reset", 1'b1, 1'b0, 5, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk_all("mid_reset", 1'b0, 1'b0, 0, 0);

    // en=0 mid-LOCKED
    s(1'b1);
    relock();
    interval();
    s(1'b1);
    relock();
    chk_all("pre_en0", 1'b1, 1'b0, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("en0_a", 1'b0, 1'b0, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("en0_b", 1'b0, 1'b0, 1, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("en0_clear", 1'b0, 1'b0, 0, 0);
    s(1'b0);
    chk_all("en1_search", 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divider_output_checker.md
Name: divider_output_checker

Overview:
- Synthesizable on-chip monitor for the far end of a clock-divider FSM output. It checks the divider's periodic pulse stream in hardware rather than against a vector file.
- It samples a single-bit stream y_in that must be high for exactly one cycle in every PERIOD cycles. It acquires phase lock and flags every deviation.
- Error and pulse statistics are exposed for LEDs or a debug readout on the Basys3 top level.

Parameters:
- PERIOD, 4: expected pulse period in clk cycles; legal range >= 2.
- LOCK_COUNT, 2: consecutive correct intervals needed to declare lock; legal range >= 1.
- CNT_W, 16: width of the saturating err_count and pulse_count.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  checker enable.
- clear  input  1  synchronous clear of both statistics counters.
- y_in  input  1  divider output under check; synchronous to clk.
- locked  output  1  high while in the LOCKED state.
- err_pulse  output  1  one-cycle strobe for each detected error.
- err_count  output  CNT_W  saturating count of errors detected while locked.
- pulse_count  output  CNT_W  saturating count of correct pulses seen while locked.

Behaviour:
- All outputs are registered. A y_in sample taken at edge t affects the outputs after edge t.
- Reset (reset==0 at an edge): state=SEARCH, k=0, good=0, locked=0, err_pulse=0, err_count=0, pulse_count=0. Reset overrides en, clear and y_in, and applies mid-operation.
- Internal counter k (width $clog2(PERIOD)) holds the number of consecutive low samples since the last high sample.
- A sample is correct when:
  - y_in=1 and k==PERIOD-1, or
  - y_in=0 and k<PERIOD-1.
- A sample is a mismatch when:
  - early: y_in=1 and k<PERIOD-1;
  - missed: y_in=0 and k==PERIOD-1.
- k update: a high sample sets k to 0; a correct low sample increments k. k never wraps on its own.
- SEARCH state:
  - y_in=0: stay in SEARCH.
  - y_in=1 (anchor): k<=0, good<=0, go to TRACK.
- TRACK state:
  - Correct high: good<=good+1. If good+1==LOCK_COUNT, go to LOCKED; otherwise stay.
  - Early: k<=0, good<=0, stay in TRACK. No error is counted.
  - Missed: go to SEARCH. No error is counted.
- LOCKED state:
  - Correct high: pulse_count++ (saturating).
  - Early: err_pulse=1 for one cycle, err_count++ (saturating), k<=0, good<=0, go to TRACK.
  - Missed: err_pulse=1 for one cycle, err_count++ (saturating), go to SEARCH.
- locked is 1 exactly when the registered state is LOCKED.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- clear=1: both counters go to 0 at the next edge. FSM state, k and good are unaffected.
- clear together with an error or pulse event: clear wins on the counter, so it ends at 0. err_pulse still fires.
- en=0:
  - State forced to SEARCH, k=0, good=0, locked=0, err_pulse=0.
  - Counters hold their values; clear still acts.
- Errors are only reported from LOCKED. Mismatches in SEARCH and TRACK are silent.

Decomposition:
- Package divider_checker_pkg holds the state typedef (enum logic [1:0] {SEARCH, TRACK, LOCKED}).
- One sub-module, sat_counter, is instantiated twice: parameter W; ports clk, reset, clr, inc, q; saturating increment; clr has priority over inc.

Test Plan (PERIOD=4, LOCK_COUNT=2 unless stated):
- Reset, then en=1 with ideal stream 1,0,0,0 repeating from sample 0 -> locked rises after the edge sampling sample 8; err_count=0; pulse_count=3 after sample 20.
- Locked, then y_in=1 at k=2 (early) -> err_pulse high for exactly one cycle, err_count=1, locked=0 for 2 intervals, then re-locks; pulse_count is unchanged in between.
- Locked, then one pulse dropped (y_in=0 at k=3) -> err_pulse once, err_count=1, state SEARCH; re-lock requires an anchor plus 2 correct intervals; no second error is flagged.
- CNT_W=3, force 10 early errors, each followed by a re-lock -> err_count stops at 7; a later clear gives 0.
- clear asserted on the same edge as a LOCKED early error -> err_pulse=1, err_count=0 afterwards.
- reset=0 for one edge mid-LOCKED with err_count=5 -> all outputs 0 next cycle. Separately, en=0 mid-LOCKED -> locked=0 and counters hold their values.
